// File: rtl/divider_result_bcd_if.sv
// Divider-to-consumer handshake: result-ready level, quotient/remainder bus,
// and the acknowledge that releases the divider from its done state.
interface divider_result_bcd_if #(
    parameter int unsigned WIDTH = 8
);
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Ack;

    modport master (output Done, Quotient, Remainder, input Ack);
    modport slave  (input Done, Quotient, Remainder, output Ack);
endinterface

// File: rtl/divider_result_bcd.sv
// Captures a divider result and converts quotient and remainder to packed BCD
// in parallel with sequential shift-add-3, one bit per clock.
module divider_result_bcd #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NDIG  = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    divider_result_bcd_if.slave  div,
    output logic [4*NDIG-1:0]    Q_bcd,
    output logic [4*NDIG-1:0]    R_bcd,
    output logic                 Valid,
    output logic                 Qidle,
    output logic                 Qconv,
    output logic                 Qack
);
    localparam int unsigned BW = 4 * NDIG;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] CONV = 3'b010;
    localparam logic [2:0] ACK  = 3'b100;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_shift, r_shift;
    logic [BW-1:0]    q_acc, r_acc;
    logic [BW-1:0]    q_adj, r_adj, q_next, r_next;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
        logic [BW-1:0] r;
        r = a;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        q_adj  = add3(q_acc);
        r_adj  = add3(r_acc);
        q_next = {q_adj[BW-2:0], q_shift[WIDTH-1]};
        r_next = {r_adj[BW-2:0], r_shift[WIDTH-1]};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            q_shift <= '0;
            r_shift <= '0;
            q_acc   <= '0;
            r_acc   <= '0;
            Q_bcd   <= '0;
            R_bcd   <= '0;
            Valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div.Done) begin
                        q_shift <= div.Quotient;
                        r_shift <= div.Remainder;
                        q_acc   <= '0;
                        r_acc   <= '0;
                        cnt     <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    // Visible outputs change only on the last shift, so the display never shows a partial value
                    q_acc   <= q_next;
                    r_acc   <= r_next;
                    q_shift <= {q_shift[WIDTH-2:0], 1'b0};
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        Q_bcd <= q_next;
                        R_bcd <= r_next;
                        Valid <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!div.Done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {Qack, Qconv, Qidle} = state;
    assign div.Ack              = (state == ACK);
endmodule

// File: tb/tb_divider_result_bcd.sv
// Bench for divider_result_bcd: directed scenarios plus randomized divider
// transactions checked against a decimal-digit reference model.
module tb_divider_result_bcd;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [11:0] Q_bcd, R_bcd;
    logic        Valid, Qidle, Qconv, Qack;

    int vectors = 0;
    int errors  = 0;

    divider_result_bcd_if #(.WIDTH(8)) bus ();

    divider_result_bcd #(.WIDTH(8), .NDIG(3)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .div   (bus),
        .Q_bcd (Q_bcd),
        .R_bcd (R_bcd),
        .Valid (Valid),
        .Qidle (Qidle),
        .Qconv (Qconv),
        .Qack  (Qack)
    );

    always #5 Clk = ~Clk;

    // Decimal digits by plain division, packed hundreds/tens/units
    function automatic logic [11:0] bcd3(input int v);
        return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start(input int q, input int r);
        bus.Quotient  = 8'(q);
        bus.Remainder = 8'(r);
        bus.Done      = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.Done = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        vectors++; if ({Qack, Qconv, Qidle} !== 3'b001) begin errors++; $display("FAIL reset_state got %b want 001", {Qack, Qconv, Qidle}); end
        vectors++; if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Valid); end
        vectors++; if (Q_bcd !== 12'h000) begin errors++; $display("FAIL reset_q got %h want 000", Q_bcd); end
        vectors++; if (R_bcd !== 12'h000) begin errors++; $display("FAIL reset_r got %h want 000", R_bcd); end
        vectors++; if (bus.Ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", bus.Ack); end
    endtask

    task automatic test_basic();
        int acks;
        start(14, 2);
        vectors++; if ({Qack, Qconv, Qidle} !== 3'b010) begin errors++; $display("FAIL basic_conv_state got %b want 010", {Qack, Qconv, Qidle}); end
        repeat (7) tick();
        vectors++; if (Valid !== 1'b0 || Q_bcd !== 12'h000) begin errors++; $display("FAIL basic_early got valid=%b q=%h want 0/000", Valid, Q_bcd); end
        tick();
        vectors++; if (Q_bcd !== 12'h014) begin errors++; $display("FAIL basic_q got %h want 014", Q_bcd); end
        vectors++; if (R_bcd !== 12'h002) begin errors++; $display("FAIL basic_r got %h want 002", R_bcd); end
        vectors++; if (Valid !== 1'b1 || bus.Ack !== 1'b1) begin errors++; $display("FAIL basic_valid_ack got %b%b want 11", Valid, bus.Ack); end
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (!bus.Ack) break;
            acks++;
            tick();
            if (i == 0) bus.Done = 1'b0;
        end
        vectors++; if (acks !== 2) begin errors++; $display("FAIL basic_ack_cycles got %0d want 2", acks); end
        vectors++; if (Qidle !== 1'b1) begin errors++; $display("FAIL basic_idle got %b want 1", Qidle); end
    endtask

    task automatic test_reset_mid_conv();
        int q, r;
        start(57, 123);
        repeat (4) tick();
        Reset = 1'b1;
        bus.Done = 1'b0;
        tick();
        Reset = 1'b0;
        vectors++; if ({Qack, Qconv, Qidle} !== 3'b001) begin errors++; $display("FAIL midrst_state got %b want 001", {Qack, Qconv, Qidle}); end
        vectors++; if (Valid !== 1'b0 || bus.Ack !== 1'b0) begin errors++; $display("FAIL midrst_valid_ack got %b%b want 00", Valid, bus.Ack); end
        vectors++; if (Q_bcd !== 12'h000 || R_bcd !== 12'h000) begin errors++; $display("FAIL midrst_bcd got %h/%h want 000/000", Q_bcd, R_bcd); end
        q = $urandom_range(0, 255);
        r = $urandom_range(0, 255);
        start(q, r);
        repeat (7) tick();
        vectors++; if (Valid !== 1'b0) begin errors++; $display("FAIL midrst_early_valid got %b want 0", Valid); end
        tick();
        vectors++; if (Q_bcd !== bcd3(q) || R_bcd !== bcd3(r)) begin errors++; $display("FAIL midrst_restart got %h/%h want %h/%h", Q_bcd, R_bcd, bcd3(q), bcd3(r)); end
        vectors++; if (Valid !== 1'b1) begin errors++; $display("FAIL midrst_restart_valid got %b want 1", Valid); end
        bus.Done = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        start(255, 0);
        repeat (8) tick();
        vectors++; if (Q_bcd !== 12'h255 || R_bcd !== 12'h000) begin errors++; $display("FAIL hold_max got %h/%h want 255/000", Q_bcd, R_bcd); end
        bus.Done = 1'b0;
        tick();
        start(99, 199);
        for (int i = 0; i < 7; i++) begin
            vectors++; if (Q_bcd !== 12'h255 || Valid !== 1'b1) begin errors++; $display("FAIL hold_during_conv cycle %0d got %h valid=%b want 255 valid=1", i, Q_bcd, Valid); end
            tick();
        end
        tick();
        vectors++; if (Q_bcd !== 12'h099 || R_bcd !== 12'h199) begin errors++; $display("FAIL hold_second got %h/%h want 099/199", Q_bcd, R_bcd); end
        bus.Done = 1'b0;
        tick();
    endtask

    task automatic test_stuck_done();
        start(42, 7);
        repeat (8) tick();
        bus.Quotient  = 8'd200;
        bus.Remainder = 8'd13;
        repeat (20) tick();
        vectors++; if ({Qack, Qconv, Qidle} !== 3'b100) begin errors++; $display("FAIL stuck_state got %b want 100", {Qack, Qconv, Qidle}); end
        vectors++; if (Q_bcd !== 12'h042 || R_bcd !== 12'h007) begin errors++; $display("FAIL stuck_bcd got %h/%h want 042/007", Q_bcd, R_bcd); end
        bus.Done = 1'b0;
        tick();
        vectors++; if (Qidle !== 1'b1) begin errors++; $display("FAIL stuck_release got %b want 1", Qidle); end
    endtask

    task automatic test_done_glitch();
        start(173, 88);
        tick();
        bus.Done      = 1'b0;
        bus.Quotient  = 8'd0;
        bus.Remainder = 8'd0;
        repeat (2) tick();
        bus.Done = 1'b1;
        repeat (5) tick();
        vectors++; if (Q_bcd !== 12'h173 || R_bcd !== 12'h088) begin errors++; $display("FAIL glitch_bcd got %h/%h want 173/088", Q_bcd, R_bcd); end
        vectors++; if (bus.Ack !== 1'b1) begin errors++; $display("FAIL glitch_ack got %b want 1", bus.Ack); end
        bus.Done = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int xs[$];
        int ys[$];
        int x, y, waited, acks;
        xs = '{200, 9};
        ys = '{3, 10};
        for (int k = 0; k < 24; k++) begin
            xs.push_back($urandom_range(0, 255));
            ys.push_back($urandom_range(1, 255));
        end
        for (int k = 0; k < xs.size(); k++) begin
            x = xs[k];
            y = ys[k];
            bus.Quotient  = 8'(x / y);
            bus.Remainder = 8'(x % y);
            bus.Done      = 1'b1;
            waited = 0;
            while (!bus.Ack && waited < 20) begin
                tick();
                waited++;
            end
            vectors++; if (waited !== 9) begin errors++; $display("FAIL b2b_latency x=%0d y=%0d got %0d cycles want 9", x, y, waited); end
            vectors++; if (Q_bcd !== bcd3(x / y) || R_bcd !== bcd3(x % y)) begin errors++; $display("FAIL b2b_result x=%0d y=%0d got %h/%h want %h/%h", x, y, Q_bcd, R_bcd, bcd3(x / y), bcd3(x % y)); end
            acks = 0;
            for (int i = 0; i < 6; i++) begin
                if (!bus.Ack) break;
                acks++;
                tick();
                if (i == 0) bus.Done = 1'b0;
            end
            bus.Done = 1'b0;
            vectors++; if (acks !== 2 || Qidle !== 1'b1) begin errors++; $display("FAIL b2b_handshake x=%0d y=%0d got acks=%0d idle=%b want 2/1", x, y, acks, Qidle); end
        end
    endtask

    initial begin
        Reset         = 1'b1;
        bus.Done      = 1'b0;
        bus.Quotient  = '0;
        bus.Remainder = '0;
        test_reset();
        test_basic();
        test_reset_mid_conv();
        test_hold();
        test_stuck_done();
        test_done_glitch();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
